// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } serial_state_e;

  // Bits needed to count 0..n inclusive.
  function automatic int count_bits(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/full_adder_dataflow.sv
// Combinational one-bit full adder used as the arithmetic cell of the serial unit.
module full_adder_dataflow (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, using a
// single full-adder cell; subtraction is a + ~b + 1.
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = count_bits(WIDTH);

  serial_state_e    state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;

  logic             sum_d;
  logic             carry_d;
  logic             last_bit_d;

  full_adder_dataflow u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (sum_d),
    .cout (carry_d)
  );

  assign last_bit_d = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Inverted B plus carry-in of 1 turns the add into a subtract.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          result_q <= {sum_d, result_q[WIDTH-1:1]};
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit_d) begin
            // On the MSB cycle carry_q is the carry into the MSB.
            cout_q  <= carry_d;
            ovf_q   <= carry_q ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=8): arithmetic corners, start
// filtering during RUN, back-to-back operation and mid-operation reset.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int tests_run = 0;
  int tests_failed = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble them so any late capture shows up.
  task automatic do_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    start = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    step();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    sub = ~sv;
  endtask

  task automatic wait_done(output int cycles, output int busy_cycles, output bit got);
    cycles = 0;
    busy_cycles = 0;
    got = 1'b0;
    while (!done && cycles < 40) begin
      if (busy) busy_cycles++;
      step();
      cycles++;
    end
    got = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    step();
    step();
    start = 1'b0;
    tests_run++;
    if ({busy, done, result, cout, overflow} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b result=%h cout=%b ovf=%b, want all zero",
               busy, done, result, cout, overflow);
    end
    rst_n = 1'b1;
    step();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_start_ignored: busy=%b want 0", busy);
    end
    $display("[TB] reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_add();
    int cyc, bcyc;
    bit got;
    do_start(8'h7F, 8'h01, 1'b0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL add1_busy_after_start: busy=%b want 1", busy);
    end
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || cyc != 8 || bcyc != 8) begin
      tests_failed++;
      $display("FAIL add1_latency: got=%0d cycles=%0d busy_cycles=%0d want 1/8/8", got, cyc, bcyc);
    end
    tests_run++;
    if ({result, cout, overflow, busy} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL add1_7F+01: result=%h cout=%b ovf=%b busy=%b want 80/0/1/0",
               result, cout, overflow, busy);
    end
    $display("[TB] add 7F+01: result=%h cout=%b ovf=%b", result, cout, overflow);
    step();
    tests_run++;
    if ({done, busy, result, overflow} !== {1'b0, 1'b0, 8'h80, 1'b1}) begin
      tests_failed++;
      $display("FAIL add1_hold: done=%b busy=%b result=%h ovf=%b want 0/0/80/1",
               done, busy, result, overflow);
    end

    do_start(8'hFF, 8'h01, 1'b0);
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || {result, cout, overflow} !== {8'h00, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL add2_FF+01: got=%0d result=%h cout=%b ovf=%b want 00/1/0",
               got, result, cout, overflow);
    end
    $display("[TB] add FF+01: result=%h cout=%b ovf=%b", result, cout, overflow);
    step();
  endtask

  task automatic test_sub();
    int cyc, bcyc;
    bit got;
    do_start(8'h05, 8'h07, 1'b1);
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || {result, cout, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL sub1_05-07: got=%0d result=%h cout=%b ovf=%b want FE/0/0",
               got, result, cout, overflow);
    end
    $display("[TB] sub 05-07: result=%h cout=%b ovf=%b", result, cout, overflow);
    step();

    do_start(8'h80, 8'h01, 1'b1);
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || {result, cout, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL sub2_80-01: got=%0d result=%h cout=%b ovf=%b want 7F/1/1",
               got, result, cout, overflow);
    end
    $display("[TB] sub 80-01: result=%h cout=%b ovf=%b", result, cout, overflow);
    step();
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc;
    bit got;
    do_start(8'h10, 8'h20, 1'b0);
    step();
    step();
    start = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    sub = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || cyc != 5 || {result, cout, overflow} !== {8'h30, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL ignore_start: got=%0d cycles=%0d result=%h cout=%b ovf=%b want 1/5/30/0/0",
               got, cyc, result, cout, overflow);
    end
    $display("[TB] ignored start: result=%h cycles=%0d", result, cyc);
    step();
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL ignore_start_idle: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    bit got;
    do_start(8'h01, 8'h02, 1'b0);
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || result !== 8'h03) begin
      tests_failed++;
      $display("FAIL b2b_first: got=%0d result=%h want 03", got, result);
    end
    do_start(8'h40, 8'h40, 1'b0);
    tests_run++;
    if ({busy, done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL b2b_no_gap: busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || (cyc + 1) != 9 || {result, cout, overflow} !== {8'h80, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_second: got=%0d spacing=%0d result=%h cout=%b ovf=%b want 1/9/80/0/1",
               got, cyc + 1, result, cout, overflow);
    end
    $display("[TB] back-to-back: spacing=%0d result=%h ovf=%b", cyc + 1, result, overflow);
    step();
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc, seen;
    bit got;
    do_start(8'h33, 8'h11, 1'b0);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({busy, done, result, cout, overflow} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_state: busy=%b done=%b result=%h cout=%b ovf=%b want 0/0/00/0/0",
               busy, done, result, cout, overflow);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      step();
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: done pulses=%0d want 0", seen);
    end
    do_start(8'h12, 8'h34, 1'b0);
    wait_done(cyc, bcyc, got);
    tests_run++;
    if (!got || {result, cout, overflow} !== {8'h46, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_after_12+34: got=%0d result=%h cout=%b ovf=%b want 46/0/0",
               got, result, cout, overflow);
    end
    $display("[TB] reset mid-op then 12+34: result=%h", result);
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
